// File: rtl/fpadder_seq_if.sv
// Handshake and operand/result bundle for the sequential single-precision adder.
interface fpadder_seq_if;
  logic        load;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] add_out;
  logic        done;
  logic        busy;

  modport master (output load, output a, output b,
                  input  add_out, input done, input busy);
  modport slave  (input  load, input a, input b,
                  output add_out, output done, output busy);
endinterface

// File: rtl/fpadder_seq.sv
// Sequential IEEE-754 single-precision adder: serial align, add/sub, serial normalize, truncation.
// Optional FPADD_SPECIAL_EN: exponent-255 operands (inf/NaN) bypass the datapath straight to DONE.
module fpadder_seq (
  input  logic          clk,
  input  logic          reset,
  fpadder_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state_reg;
  logic        sign_reg;
  logic [8:0]  exp_reg;
  logic [23:0] ml_reg;
  logic [23:0] ms_reg;
  logic [24:0] sum_reg;
  logic [4:0]  cnt_reg;
  logic        sub_reg;
  logic        carry_reg;
  logic        special_reg;
  logic [31:0] special_val_reg;

  logic        a_larger;
  logic [31:0] op_l;
  logic [31:0] op_s;
  logic [7:0]  exp_l;
  logic [7:0]  exp_s;
  logic [7:0]  exp_diff;
  logic [4:0]  shift_amt;
  logic [23:0] sig_l;
  logic [23:0] sig_s;
  logic        spec_hit;
  logic [31:0] spec_val;

  // Magnitude ordering on the raw exponent/fraction bits; ties keep A as the larger.
  assign a_larger  = (bus.a[30:0] >= bus.b[30:0]);
  assign op_l      = a_larger ? bus.a : bus.b;
  assign op_s      = a_larger ? bus.b : bus.a;
  assign exp_l     = op_l[30:23];
  assign exp_s     = op_s[30:23];
  assign exp_diff  = exp_l - exp_s;
  assign shift_amt = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];
  assign sig_l     = (exp_l == 8'd0) ? 24'd0 : {1'b1, op_l[22:0]};
  assign sig_s     = (exp_s == 8'd0) ? 24'd0 : {1'b1, op_s[22:0]};

`ifdef FPADD_SPECIAL_EN
  logic a_max_exp;
  logic b_max_exp;
  logic a_nan;
  logic b_nan;

  assign a_max_exp = &bus.a[30:23];
  assign b_max_exp = &bus.b[30:23];
  assign a_nan     = a_max_exp && (|bus.a[22:0]);
  assign b_nan     = b_max_exp && (|bus.b[22:0]);
  assign spec_hit  = a_max_exp || b_max_exp;
  // Opposite-signed infinities have no meaningful sum, so they join NaN inputs on the quiet NaN.
  assign spec_val  = (a_nan || b_nan || (a_max_exp && b_max_exp && (bus.a[31] != bus.b[31])))
                     ? 32'h7FC0_0000
                     : (a_max_exp ? bus.a : bus.b);
`else
  assign spec_hit  = 1'b0;
  assign spec_val  = 32'h0000_0000;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      sign_reg        <= 1'b0;
      exp_reg         <= 9'd0;
      ml_reg          <= 24'd0;
      ms_reg          <= 24'd0;
      sum_reg         <= 25'd0;
      cnt_reg         <= 5'd0;
      sub_reg         <= 1'b0;
      carry_reg       <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= 32'd0;
      bus.add_out     <= 32'd0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load && !bus.busy) begin
            sign_reg        <= op_l[31];
            exp_reg         <= {1'b0, exp_l};
            ml_reg          <= sig_l;
            ms_reg          <= sig_s;
            cnt_reg         <= shift_amt;
            sub_reg         <= op_l[31] ^ op_s[31];
            carry_reg       <= 1'b0;
            sum_reg         <= 25'd0;
            special_reg     <= spec_hit;
            special_val_reg <= spec_val;
            bus.busy        <= 1'b1;
            state_reg       <= spec_hit ? DONE : ALIGN;
          end
        end

        ALIGN: begin
          if (cnt_reg != 5'd0) begin
            ms_reg  <= ms_reg >> 1;
            cnt_reg <= cnt_reg - 5'd1;
          end else begin
            state_reg <= ADD;
          end
        end

        ADD: begin
          // Larger magnitude is on ml_reg, so the difference never goes negative.
          if (sub_reg)
            sum_reg <= {1'b0, ml_reg} - {1'b0, ms_reg};
          else
            sum_reg <= {1'b0, ml_reg} + {1'b0, ms_reg};
          state_reg <= NORM;
        end

        NORM: begin
          if (sum_reg == 25'd0) begin
            sign_reg  <= 1'b0;
            exp_reg   <= 9'd0;
            state_reg <= DONE;
          end else if (sum_reg[24]) begin
            sum_reg   <= sum_reg >> 1;
            exp_reg   <= exp_reg + 9'd1;
            carry_reg <= 1'b1;
            state_reg <= DONE;
          end else if (sum_reg[23]) begin
            state_reg <= DONE;
          end else if (exp_reg <= 9'd1) begin
            // A further left shift would land in the denormal range: flush, keep the sign.
            exp_reg   <= 9'd0;
            sum_reg   <= 25'd0;
            state_reg <= DONE;
          end else begin
            sum_reg <= sum_reg << 1;
            exp_reg <= exp_reg - 9'd1;
          end
        end

        DONE: begin
          if (special_reg)
            bus.add_out <= special_val_reg;
          else if (carry_reg && (exp_reg >= 9'd255))
            bus.add_out <= {sign_reg, 8'hFF, 23'd0};
          else
            bus.add_out <= {sign_reg, exp_reg[7:0], sum_reg[22:0]};
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadder_seq.sv
// Directed bench for fpadder_seq: hand-computed sums, latencies, ignored loads and mid-run reset.
module tb_fpadder_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   extra;
  bit   seen;

  always #5 clk = ~clk;

  fpadder_seq_if bus ();

  fpadder_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Caller is positioned away from the clock edge; load is accepted on the next rising edge.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_r, input int exp_lat);
    int  cyc;
    bit  got;
    bus.load = 1'b1;
    bus.a    = av;
    bus.b    = bv;
    @(posedge clk); #1;
    bus.load = 1'b0;
    chk({tag, "_busy_hi"}, {31'd0, bus.busy}, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) got = 1'b1;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_result"}, bus.add_out, exp_r);
    chk({tag, "_busy_lo"}, {31'd0, bus.busy}, 32'd0);
    $display("op %s a=%h b=%h add_out=%h latency=%0d", tag, av, bv, bus.add_out, cyc);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.a    = 32'd0;
    bus.b    = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_add_out", bus.add_out, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4);
    @(posedge clk); #1;
    chk("done_pulse_drop", {31'd0, bus.done}, 32'd0);
    chk("add_out_held", bus.add_out, 32'h4000_0000);

    run_op("align_s2", 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 6);
    run_op("sub_k2", 32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 7);
    run_op("cancel_zero", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4);
    run_op("truncate_s24", 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 28);
    run_op("neg_carry", 32'hC000_0000, 32'hC000_0000, 32'hC080_0000, 4);
    run_op("b_larger_neg", 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000, 6);
    run_op("overflow_inf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4);
    run_op("denorm_flush", 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 29);
    run_op("neg_zeros", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4);

    // New load pulsed mid-operation must not disturb the running add.
    bus.load = 1'b1;
    bus.a    = 32'h3F80_0000;
    bus.b    = 32'h3F80_0000;
    @(posedge clk); #1;
    bus.load = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      if (n == 1) begin
        bus.load = 1'b1;
        bus.a    = 32'h3FC0_0000;
        bus.b    = 32'h3E80_0000;
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    bus.load = 1'b0;
    chk("busy_load_latency", n, 4);
    chk("busy_load_result", bus.add_out, 32'h4000_0000);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    chk("busy_load_no_second_done", extra, 0);
    $display("op busy_load add_out=%h latency=%0d extra_done=%0d", bus.add_out, n, extra);

    // Reset during ALIGN aborts the operation and clears the result.
    bus.load = 1'b1;
    bus.a    = 32'h4B80_0000;
    bus.b    = 32'h3F80_0000;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_add_out", bus.add_out, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    chk("abort_no_done", extra, 0);
    $display("op abort add_out=%h busy=%0d done_count=%0d", bus.add_out, bus.busy, extra);
    run_op("after_abort", 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 6);

`ifdef FPADD_SPECIAL_EN
    run_op("inf_plus_one", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1);
    run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1);
    run_op("nan_in", 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 1);
`else
    run_op("exp255_plain", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 29);
    run_op("exp255_cancel", 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
